// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, receiver error codes and the
// receiver FSM state enum.
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10,
        FLIT_DATA = 2'b11
    } flit_type_e;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_ORPHAN      = 2'b01;
    localparam logic [1:0] ERR_HEAD_IN_PKT = 2'b10;
    localparam logic [1:0] ERR_VCH_CHANGE  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } rx_state_e;

endpackage

// File: rtl/pkt_recv_if.sv
// Incoming flit bus: flit data (type in the top two bits), valid strobe and
// virtual channel. The sender uses the master view, the receiver the slave view.
interface pkt_recv_if #(
    parameter int DATAW = 66,
    parameter int VCHW  = 1
);
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;

    modport master (output idata, output ivalid, output ivch);
    modport slave  (input  idata, input  ivalid, input  ivch);
endinterface

// File: rtl/pkt_recv_popcnt.sv
// 64-bit combinational population count, used by the optional toggle counter
// (PKT_RECV_TOGGLE_CNT_EN) of pkt_recv.
module pkt_recv_popcnt (
    input  logic [63:0] din,
    output logic [6:0]  ones
);

    // Sum the set bits of the input word
    always_comb begin
        ones = '0;
        for (int i = 0; i < 64; i++) begin
            ones = ones + 7'(din[i]);
        end
    end

endmodule

// File: rtl/pkt_recv.sv
// Packet receiver: tracks HEAD/DATA/TAIL framing per packet, reports completed
// packets (length, destination, running count) and flags protocol errors.
// Optional macro PKT_RECV_TOGGLE_CNT_EN adds tog_cnt, a saturating count of
// bit toggles between successive DATA flit bodies.
module pkt_recv
    import noc_pkg::*;
#(
    parameter int DATAW = 66,
    parameter int VCHW  = 1,
    parameter int LENW  = 16
) (
    input  logic            clk,
    input  logic            rst_,
    pkt_recv_if.slave       in_flit,
    output logic            pkt_done,
    output logic [LENW-1:0] pkt_len,
    output logic [31:0]     pkt_dst,
    output logic [31:0]     pkt_cnt,
    output logic            err,
    output logic [1:0]      err_code
`ifdef PKT_RECV_TOGGLE_CNT_EN
    ,
    output logic [31:0]     tog_cnt
`endif
);

    rx_state_e       state_q;
    rx_state_e       state_d;
    flit_type_e      ftype;
    logic [VCHW-1:0] vch_q;
    logic [LENW-1:0] len_cnt;
    logic            done_d;
    logic            err_d;
    logic [1:0]      err_code_d;
    logic            head_take;
    logic            len_inc;

    assign ftype = flit_type_e'(in_flit.idata[DATAW-1 -: 2]);

    // FSM state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify the accepted flit against the current state: next state,
    // completion/error events and datapath strobes
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code;
        head_take  = 1'b0;
        len_inc    = 1'b0;
        if (in_flit.ivalid) begin
            case (ftype)
                FLIT_HEAD: begin
                    head_take = 1'b1;
                    state_d   = ST_BODY;
                    if (state_q == ST_BODY) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_HEAD_IN_PKT;
                    end
                end
                FLIT_DATA, FLIT_TAIL: begin
                    if (state_q == ST_IDLE) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ORPHAN;
                    end else if (in_flit.ivch != vch_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_VCH_CHANGE;
                        state_d    = ST_IDLE;
                    end else if (ftype == FLIT_TAIL) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        len_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Packet datapath: header latch, payload counter, reported results and pulses
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            vch_q    <= '0;
            len_cnt  <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            pkt_dst  <= '0;
            pkt_cnt  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            pkt_done <= done_d;
            err      <= err_d;
            err_code <= err_code_d;
            if (head_take) begin
                pkt_dst <= in_flit.idata[31:0];
                vch_q   <= in_flit.ivch;
                len_cnt <= '0;
            end else if (len_inc && (len_cnt != '1)) begin
                len_cnt <= len_cnt + 1'b1;
            end
            if (done_d) begin
                pkt_len <= len_cnt;
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

`ifdef PKT_RECV_TOGGLE_CNT_EN
    logic [63:0] prev_body;
    logic [6:0]  body_ones;
    logic [32:0] tog_sum;

    pkt_recv_popcnt u_popcnt (
        .din  (in_flit.idata[63:0] ^ prev_body),
        .ones (body_ones)
    );

    assign tog_sum = {1'b0, tog_cnt} + {26'd0, body_ones};

    // Accumulate toggles between successive DATA bodies; a HEAD restarts the reference
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_body <= '0;
            tog_cnt   <= '0;
        end else if (in_flit.ivalid) begin
            if (ftype == FLIT_HEAD) begin
                prev_body <= '0;
            end else if (ftype == FLIT_DATA) begin
                prev_body <= in_flit.idata[63:0];
                tog_cnt   <= tog_sum[32] ? 32'hFFFF_FFFF : tog_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_recv.sv
// Testbench for pkt_recv: reset values, a table of directed flit vectors,
// hand-written multi-cycle sequences and randomized traffic against a
// packet-level reference model.
`timescale 1ns/1ps
module tb_pkt_recv;
    import noc_pkg::*;

    localparam int DATAW    = 66;
    localparam int VCHW     = 1;
    localparam int LENW     = 16;
    localparam int SAT_LENW = 3;

    logic clk = 1'b0;
    logic rst_;

    pkt_recv_if #(.DATAW(DATAW), .VCHW(VCHW)) flit_bus ();

    logic            pkt_done;
    logic [LENW-1:0] pkt_len;
    logic [31:0]     pkt_dst;
    logic [31:0]     pkt_cnt;
    logic            err;
    logic [1:0]      err_code;

    logic                sat_done;
    logic [SAT_LENW-1:0] sat_len;
    logic [31:0]         sat_dst;
    logic [31:0]         sat_cnt;
    logic                sat_err;
    logic [1:0]          sat_code;

`ifdef PKT_RECV_TOGGLE_CNT_EN
    logic [31:0] tog_cnt;
    logic [31:0] sat_tog;
`endif

    int checks = 0;
    int errors = 0;

    pkt_recv #(.DATAW(DATAW), .VCHW(VCHW), .LENW(LENW)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .in_flit  (flit_bus),
        .pkt_done (pkt_done),
        .pkt_len  (pkt_len),
        .pkt_dst  (pkt_dst),
        .pkt_cnt  (pkt_cnt),
        .err      (err),
        .err_code (err_code)
`ifdef PKT_RECV_TOGGLE_CNT_EN
        ,
        .tog_cnt  (tog_cnt)
`endif
    );

    // Narrow-counter instance sharing the same bus, used for length saturation
    pkt_recv #(.DATAW(DATAW), .VCHW(VCHW), .LENW(SAT_LENW)) sat_dut (
        .clk      (clk),
        .rst_     (rst_),
        .in_flit  (flit_bus),
        .pkt_done (sat_done),
        .pkt_len  (sat_len),
        .pkt_dst  (sat_dst),
        .pkt_cnt  (sat_cnt),
        .err      (sat_err),
        .err_code (sat_code)
`ifdef PKT_RECV_TOGGLE_CNT_EN
        ,
        .tog_cnt  (sat_tog)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  ftype;
        logic        vch;
        logic [63:0] body;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [15:0] exp_len;
        logic [31:0] exp_dst;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[24];

    // Packet-level reference model state
    bit          m_open;
    logic        m_vch;
    logic [63:0] m_payload[$];
    logic        m_done;
    logic        m_err;
    logic [1:0]  m_code;
    logic [15:0] m_len;
    logic [31:0] m_dst;
    logic [31:0] m_cnt;

    function automatic vec_t mk(input logic valid, input logic [1:0] ftype, input logic vch,
                                input logic [63:0] body, input logic done, input logic e,
                                input logic [1:0] code, input logic [15:0] len,
                                input logic [31:0] dst, input logic [31:0] cnt);
        vec_t v;
        v.valid = valid; v.ftype = ftype; v.vch = vch; v.body = body;
        v.exp_done = done; v.exp_err = e; v.exp_code = code;
        v.exp_len = len; v.exp_dst = dst; v.exp_cnt = cnt;
        return v;
    endfunction

    function automatic void modelReset();
        m_open = 1'b0;
        m_vch  = 1'b0;
        m_payload.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        m_len  = '0;
        m_dst  = '0;
        m_cnt  = '0;
    endfunction

    function automatic void modelStep(input logic valid, input logic [1:0] ftype,
                                      input logic vch, input logic [63:0] body);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!valid || ftype == 2'b00) return;
        if (ftype == 2'b01) begin
            if (m_open) begin
                m_err  = 1'b1;
                m_code = 2'b10;
            end
            m_open = 1'b1;
            m_vch  = vch;
            m_payload.delete();
            m_dst  = body[31:0];
        end else if (!m_open) begin
            m_err  = 1'b1;
            m_code = 2'b01;
        end else if (vch != m_vch) begin
            m_err  = 1'b1;
            m_code = 2'b11;
            m_open = 1'b0;
        end else if (ftype == 2'b10) begin
            m_done = 1'b1;
            m_len  = (m_payload.size() > 65535) ? 16'hFFFF : 16'(m_payload.size());
            m_cnt  = m_cnt + 1;
            m_open = 1'b0;
        end else begin
            m_payload.push_back(body);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic done, input logic e, input logic [1:0] code,
                            input logic [15:0] len, input logic [31:0] dst, input logic [31:0] cnt);
        checkOutput({tag, ".pkt_done"}, 64'(pkt_done), 64'(done));
        checkOutput({tag, ".err"},      64'(err),      64'(e));
        checkOutput({tag, ".err_code"}, 64'(err_code), 64'(code));
        checkOutput({tag, ".pkt_len"},  64'(pkt_len),  64'(len));
        checkOutput({tag, ".pkt_dst"},  64'(pkt_dst),  64'(dst));
        checkOutput({tag, ".pkt_cnt"},  64'(pkt_cnt),  64'(cnt));
    endtask

    // Called at a falling edge: drive one flit, return at the next falling edge
    task automatic applyStimulus(input logic valid, input logic [1:0] ftype, input logic vch, input logic [63:0] body);
        flit_bus.ivalid = valid;
        flit_bus.idata  = {ftype, body};
        flit_bus.ivch   = vch;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        flit_bus.ivalid = 1'b0;
        #2 rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        logic err_seen;
        logic [1:0] ft;

        rst_ = 1'b0;
        flit_bus.ivalid = 1'b0;
        flit_bus.idata  = '0;
        flit_bus.ivch   = '0;

        // Reset values
        #3;
        checkAll("reset", 1'b0, 1'b0, 2'b00, 16'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        // Directed vector table
        vecs[0]  = mk(1, 2'b11, 0, 64'h0,                   0, 1, 2'b01, 0, 32'h00, 0);
        vecs[1]  = mk(0, 2'b11, 0, 64'h0,                   0, 0, 2'b01, 0, 32'h00, 0);
        vecs[2]  = mk(1, 2'b00, 0, 64'h0,                   0, 0, 2'b01, 0, 32'h00, 0);
        vecs[3]  = mk(1, 2'b01, 0, 64'hDEAD_BEEF_0000_0004, 0, 0, 2'b01, 0, 32'h04, 0);
        vecs[4]  = mk(1, 2'b11, 1, 64'h1,                   0, 1, 2'b11, 0, 32'h04, 0);
        vecs[5]  = mk(1, 2'b10, 1, 64'h2,                   0, 1, 2'b01, 0, 32'h04, 0);
        vecs[6]  = mk(1, 2'b01, 1, 64'h1234_5678_0000_0010, 0, 0, 2'b01, 0, 32'h10, 0);
        vecs[7]  = mk(1, 2'b11, 1, 64'h3,                   0, 0, 2'b01, 0, 32'h10, 0);
        vecs[8]  = mk(1, 2'b11, 1, 64'h4,                   0, 0, 2'b01, 0, 32'h10, 0);
        vecs[9]  = mk(0, 2'b10, 1, 64'h5,                   0, 0, 2'b01, 0, 32'h10, 0);
        vecs[10] = mk(1, 2'b10, 1, 64'h6,                   1, 0, 2'b01, 2, 32'h10, 1);
        vecs[11] = mk(1, 2'b01, 0, 64'h0000_0000_0000_0022, 0, 0, 2'b01, 2, 32'h22, 1);
        vecs[12] = mk(1, 2'b11, 0, 64'h7,                   0, 0, 2'b01, 2, 32'h22, 1);
        vecs[13] = mk(1, 2'b01, 0, 64'h0000_0000_0000_0009, 0, 1, 2'b10, 2, 32'h09, 1);
        vecs[14] = mk(1, 2'b11, 0, 64'h8,                   0, 0, 2'b10, 2, 32'h09, 1);
        vecs[15] = mk(1, 2'b11, 0, 64'h9,                   0, 0, 2'b10, 2, 32'h09, 1);
        vecs[16] = mk(1, 2'b10, 0, 64'hA,                   1, 0, 2'b10, 2, 32'h09, 2);
        vecs[17] = mk(1, 2'b10, 0, 64'hB,                   0, 1, 2'b01, 2, 32'h09, 2);
        vecs[18] = mk(1, 2'b01, 1, 64'h0000_0000_0000_0033, 0, 0, 2'b01, 2, 32'h33, 2);
        vecs[19] = mk(1, 2'b10, 1, 64'hC,                   1, 0, 2'b01, 0, 32'h33, 3);
        vecs[20] = mk(1, 2'b01, 0, 64'h0000_0000_0000_0044, 0, 0, 2'b01, 0, 32'h44, 3);
        vecs[21] = mk(1, 2'b01, 1, 64'h0000_0000_0000_0055, 0, 1, 2'b10, 0, 32'h55, 3);
        vecs[22] = mk(1, 2'b11, 1, 64'hD,                   0, 0, 2'b10, 0, 32'h55, 3);
        vecs[23] = mk(1, 2'b10, 1, 64'hE,                   1, 0, 2'b10, 1, 32'h55, 4);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].ftype, vecs[i].vch, vecs[i].body);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_code,
                     vecs[i].exp_len, vecs[i].exp_dst, vecs[i].exp_cnt);
        end

        // Length saturation on the narrow instance: 10 DATA flits, 3-bit counter
        applyStimulus(1, 2'b01, 0, 64'h66);
        for (int i = 0; i < 10; i++) applyStimulus(1, 2'b11, 0, 64'(i));
        applyStimulus(1, 2'b10, 0, 64'h0);
        checkOutput("sat.pkt_done", 64'(sat_done), 64'd1);
        checkOutput("sat.pkt_len",  64'(sat_len),  64'd7);
        checkAll("nosat", 1'b1, 1'b0, 2'b10, 16'd10, 32'h66, 32'd5);

        // Ten packets of 20 DATA each with 7-cycle idle gaps
        err_seen = 1'b0;
        for (int p = 0; p < 10; p++) begin
            applyStimulus(1, 2'b01, 0, 64'h04);
            err_seen |= err;
            for (int d = 0; d < 20; d++) begin
                applyStimulus(1, 2'b11, 0, {$urandom, $urandom});
                err_seen |= err;
            end
            applyStimulus(1, 2'b10, 0, 64'h0);
            err_seen |= err;
            checkAll($sformatf("pkt%0d", p), 1'b1, 1'b0, 2'b10, 16'd20, 32'h04, 32'(6 + p));
            for (int g = 0; g < 7; g++) begin
                applyStimulus(0, 2'b00, 0, 64'h0);
                err_seen |= err;
                if (g == 0) checkOutput($sformatf("pkt%0d.pulse_end", p), 64'(pkt_done), 64'd0);
            end
        end
        checkOutput("pkts.no_err", 64'(err_seen), 64'd0);
        checkOutput("pkts.pkt_cnt", 64'(pkt_cnt), 64'd15);

        // Reset in the middle of a packet
        applyStimulus(1, 2'b01, 0, 64'h77);
        applyStimulus(1, 2'b11, 0, 64'h1);
        flit_bus.ivalid = 1'b0;
        #2 rst_ = 1'b0;
        #1;
        checkAll("async_rst", 1'b0, 1'b0, 2'b00, 16'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        applyStimulus(1, 2'b10, 0, 64'h0);
        checkAll("post_rst_tail", 1'b0, 1'b1, 2'b01, 16'd0, 32'd0, 32'd0);

        // Randomized traffic against the reference model
        pulseReset();
        modelReset();
        for (int n = 0; n < 600; n++) begin
            logic        v;
            logic        vc;
            logic [63:0] b;
            int          r;
            v  = ($urandom_range(0, 7) != 0);
            r  = $urandom_range(0, 15);
            ft = (r == 0) ? 2'b00 : (r < 3) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
            vc = ($urandom_range(0, 11) == 0);
            b  = {$urandom, $urandom};
            applyStimulus(v, ft, vc, b);
            modelStep(v, ft, vc, b);
            checkAll($sformatf("rand%0d", n), m_done, m_err, m_code, m_len, m_dst, m_cnt);
        end

`ifdef PKT_RECV_TOGGLE_CNT_EN
        // Toggle counter on successive DATA bodies
        pulseReset();
        applyStimulus(1, 2'b11, 0, 64'h0);
        checkOutput("tog.first", 64'(tog_cnt), 64'd0);
        applyStimulus(1, 2'b11, 0, 64'hFFFF_FFFF_0000_0000);
        checkOutput("tog.second", 64'(tog_cnt), 64'd32);
        applyStimulus(1, 2'b11, 0, 64'h0000_0000_FFFF_FFFF);
        checkOutput("tog.third", 64'(tog_cnt), 64'd96);
        applyStimulus(1, 2'b01, 0, 64'h1);
        applyStimulus(1, 2'b11, 0, 64'hF);
        checkOutput("tog.after_head", 64'(tog_cnt), 64'd100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
